// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: receive-side framer behind the RGMII PHY interface.
// It registers the GMII receive inputs, finds preamble and SFD, pairs nibbles
// into bytes in MII (10/100) mode, and emits each frame as a byte-wide
// AXI-stream with tlast and a bad-frame flag. The FCS is passed through. There
// is no backpressure.
// Optional feature macro: GMII_RX_FCS_CHECK_EN. It adds a CRC-32 residue check
// and the error_bad_fcs output.
module gmii_rx_framer #(
    parameter int MAX_FRAME_LEN = 1522,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           gmii_rxd,
    input  logic                 gmii_rx_dv,
    input  logic                 gmii_rx_er,
    input  logic                 clk_enable,
    input  logic                 mii_select,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 error_bad_frame,
`ifdef GMII_RX_FCS_CHECK_EN
    output logic                 error_bad_fcs,
`endif
    output logic [CNT_WIDTH-1:0] frame_len
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_WAIT_END = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_LEN_C = CNT_WIDTH'(MAX_FRAME_LEN);
    localparam logic [7:0]           PRE_BYTE_C = 8'h55;
    localparam logic [7:0]           SFD_BYTE_C = 8'hD5;

`ifdef GMII_RX_FCS_CHECK_EN
    localparam logic [31:0] CRC_INIT_C    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE_C = 32'hDEBB_20E3;

    // Reflected CRC-32 (0x04C11DB7, reversed form 0xEDB88320), one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data_in);
        logic [31:0] c;
        c = crc_in ^ {24'h00_0000, data_in};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction
`endif

    // Input stage: these registers load only on enabled cycles.
    logic [7:0]           rxd_q;
    logic                 dv_q;
    logic                 er_q;
    logic                 mii_q;
    logic                 in_vld_q;

    // Framing state.
    state_t               state_q, state_d;
    logic [3:0]           prev_nib_q, prev_nib_d;
    logic                 nib_vld_q, nib_vld_d;
    logic                 phase_q, phase_d;
    logic                 frame_mii_q, frame_mii_d;
    logic [7:0]           hold_q, hold_d;
    logic                 hold_vld_q, hold_vld_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
`ifdef GMII_RX_FCS_CHECK_EN
    logic [31:0]          crc_q, crc_d;
    logic                 bad_fcs_q, bad_fcs_d;
`endif

    // Output registers.
    logic [7:0]           tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;
    logic                 tuser_q, tuser_d;
    logic                 bad_frame_q, bad_frame_d;
    logic [CNT_WIDTH-1:0] frame_len_q, frame_len_d;

    // Combinational helpers.
    logic                 step_s;
    logic [7:0]           byte_s;
    logic                 win_full_s;
    logic                 byte_done_s;
    logic                 odd_nib_s;
    logic                 fcs_bad_s;
    logic                 end_bad_s;

    // The FSM advances only on enabled cycles, and only once the input stage has been loaded after reset.
    assign step_s      = clk_enable & in_vld_q;
    // MII sliding window: the current nibble is the high half and the previous nibble is the low half.
    assign byte_s      = mii_q ? {rxd_q[3:0], prev_nib_q} : rxd_q;
    assign win_full_s  = ~mii_q | nib_vld_q;
    assign byte_done_s = ~mii_q | phase_q;
    assign odd_nib_s   = frame_mii_q & phase_q;
`ifdef GMII_RX_FCS_CHECK_EN
    assign fcs_bad_s   = (crc_q != CRC_RESIDUE_C);
`else
    assign fcs_bad_s   = 1'b0;
`endif
    assign end_bad_s   = err_q | odd_nib_s | fcs_bad_s;

    // Next-state and output decode for the framing FSM.
    always_comb begin
        state_d     = state_q;
        prev_nib_d  = prev_nib_q;
        nib_vld_d   = nib_vld_q;
        phase_d     = phase_q;
        frame_mii_d = frame_mii_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
`ifdef GMII_RX_FCS_CHECK_EN
        crc_d       = crc_q;
        bad_fcs_d   = 1'b0;
`endif
        tdata_d     = tdata_q;
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        tuser_d     = 1'b0;
        bad_frame_d = 1'b0;
        frame_len_d = frame_len_q;

        if (step_s) begin
            prev_nib_d = rxd_q[3:0];
            nib_vld_d  = dv_q;
            case (state_q)
                ST_IDLE: begin
                    if (dv_q && win_full_s) begin
                        if (byte_s == PRE_BYTE_C) begin
                            state_d = ST_PREAMBLE;
                        end else begin
                            state_d = ST_WAIT_END;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (!dv_q) begin
                        state_d = ST_IDLE;
                    end else if (er_q) begin
                        state_d = ST_WAIT_END;
                    end else if (byte_s == PRE_BYTE_C) begin
                        state_d = ST_PREAMBLE;
                    end else if (byte_s == SFD_BYTE_C) begin
                        state_d     = ST_PAYLOAD;
                        cnt_d       = '0;
                        err_d       = 1'b0;
                        phase_d     = 1'b0;
                        hold_vld_d  = 1'b0;
                        frame_mii_d = mii_q;
`ifdef GMII_RX_FCS_CHECK_EN
                        crc_d       = CRC_INIT_C;
`endif
                    end else begin
                        state_d = ST_WAIT_END;
                    end
                end
                ST_PAYLOAD: begin
                    if (!dv_q) begin
                        state_d    = ST_IDLE;
                        hold_vld_d = 1'b0;
                        if (hold_vld_q) begin
                            tvalid_d    = 1'b1;
                            tlast_d     = 1'b1;
                            tdata_d     = hold_q;
                            tuser_d     = end_bad_s;
                            bad_frame_d = end_bad_s;
                            frame_len_d = cnt_q;
`ifdef GMII_RX_FCS_CHECK_EN
                            bad_fcs_d   = fcs_bad_s;
`endif
                        end else begin
                            tvalid_d = 1'b0;
                        end
                    end else begin
                        // A mode change inside a frame is unsupported, so the frame is marked bad.
                        err_d   = err_q | er_q | (mii_q != frame_mii_q);
                        phase_d = mii_q ? ~phase_q : 1'b0;
                        if (byte_done_s) begin
                            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
`ifdef GMII_RX_FCS_CHECK_EN
                            crc_d = crc32_byte(crc_q, byte_s);
`endif
                            if (cnt_q == MAX_LEN_C) begin
                                // Byte MAX+1 arrived: close the frame as truncated and drop the rest.
                                state_d     = ST_WAIT_END;
                                hold_vld_d  = 1'b0;
                                tvalid_d    = 1'b1;
                                tlast_d     = 1'b1;
                                tdata_d     = hold_q;
                                tuser_d     = 1'b1;
                                bad_frame_d = 1'b1;
                                frame_len_d = cnt_q;
                            end else begin
                                hold_d     = byte_s;
                                hold_vld_d = 1'b1;
                                if (hold_vld_q) begin
                                    tvalid_d = 1'b1;
                                    tdata_d  = hold_q;
                                end else begin
                                    tvalid_d = 1'b0;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end
                end
                ST_WAIT_END: begin
                    if (dv_q) begin
                        state_d = ST_WAIT_END;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_WAIT_END;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Input stage capture, qualified by clk_enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_q    <= 8'h00;
            dv_q     <= 1'b0;
            er_q     <= 1'b0;
            mii_q    <= 1'b0;
            in_vld_q <= 1'b0;
        end else if (clk_enable) begin
            rxd_q    <= gmii_rxd;
            dv_q     <= gmii_rx_dv;
            er_q     <= gmii_rx_er;
            mii_q    <= mii_select;
            in_vld_q <= 1'b1;
        end
    end

    // Framing state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_END;
            prev_nib_q  <= 4'h0;
            nib_vld_q   <= 1'b0;
            phase_q     <= 1'b0;
            frame_mii_q <= 1'b0;
            hold_q      <= 8'h00;
            hold_vld_q  <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
`ifdef GMII_RX_FCS_CHECK_EN
            crc_q       <= CRC_INIT_C;
            bad_fcs_q   <= 1'b0;
`endif
            tdata_q     <= 8'h00;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            bad_frame_q <= 1'b0;
            frame_len_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_nib_q  <= prev_nib_d;
            nib_vld_q   <= nib_vld_d;
            phase_q     <= phase_d;
            frame_mii_q <= frame_mii_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`ifdef GMII_RX_FCS_CHECK_EN
            crc_q       <= crc_d;
            bad_fcs_q   <= bad_fcs_d;
`endif
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            bad_frame_q <= bad_frame_d;
            frame_len_q <= frame_len_d;
        end
    end

    assign m_axis_tdata    = tdata_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign m_axis_tuser    = tuser_q;
    assign error_bad_frame = bad_frame_q;
    assign frame_len       = frame_len_q;
`ifdef GMII_RX_FCS_CHECK_EN
    assign error_bad_fcs   = bad_fcs_q;
`endif

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Self-checking bench for gmii_rx_framer. It drives directed and random frames
// in GMII and MII modes. Expected beats come from a frame-level model:
// truncation, error and odd-nibble rules applied to the payload list.
module tb_gmii_rx_framer;

    localparam int MAXL = 1522;
    localparam int CW   = 16;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    gmii_rxd = 8'h00;
    logic          gmii_rx_dv = 1'b0;
    logic          gmii_rx_er = 1'b0;
    logic          clk_enable = 1'b0;
    logic          mii_select = 1'b0;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          error_bad_frame;
    logic [CW-1:0] frame_len;
`ifdef GMII_RX_FCS_CHECK_EN
    logic          error_bad_fcs;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int t_first    = 0;
    int t_dvlow    = 0;
    int last_len   = 0;

    logic [7:0] act_d[$];
    logic       act_l[$];
    logic       act_u[$];
    int         act_c[$];
    int         n_pulse = 0;
    int         n_fcs   = 0;

    gmii_rx_framer #(.MAX_FRAME_LEN(MAXL), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .gmii_rxd        (gmii_rxd),
        .gmii_rx_dv      (gmii_rx_dv),
        .gmii_rx_er      (gmii_rx_er),
        .clk_enable      (clk_enable),
        .mii_select      (mii_select),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .error_bad_frame (error_bad_frame),
`ifdef GMII_RX_FCS_CHECK_EN
        .error_bad_fcs   (error_bad_fcs),
`endif
        .frame_len       (frame_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid) begin
                act_d.push_back(m_axis_tdata);
                act_l.push_back(m_axis_tlast);
                act_u.push_back(m_axis_tuser);
                act_c.push_back(cyc);
            end
            if (error_bad_frame) n_pulse <= n_pulse + 1;
`ifdef GMII_RX_FCS_CHECK_EN
            if (error_bad_fcs) n_fcs <= n_fcs + 1;
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ethernet FCS: reflected CRC-32, transmitted inverted, least significant byte first.
    function automatic bq_t make_frame(input int nd);
        bq_t q;
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < nd; i++) begin
            q.push_back(8'($urandom));
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) q.push_back(c[8*k +: 8]);
        return q;
    endfunction

    task automatic drv(input bit en, input bit dv, input bit er, input logic [7:0] d, input bit mii);
        @(posedge clk);
        #2;
        clk_enable = en;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
        mii_select = mii;
    endtask

    // One enabled unit (byte or nibble), preceded by period-1 disabled cycles carrying junk.
    task automatic put(input bit mii, input int period, input bit dv, input bit er, input logic [7:0] v);
        for (int p = 1; p < period; p++) drv(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), mii);
        drv(1'b1, dv, er, mii ? {4'($urandom), v[3:0]} : v, mii);
    endtask

    task automatic put_byte(input bit mii, input int period, input bit er, input logic [7:0] b);
        if (mii) begin
            put(1'b1, period, 1'b1, er, {4'h0, b[3:0]});
            put(1'b1, period, 1'b1, er, {4'h0, b[7:4]});
        end else begin
            put(1'b0, period, 1'b1, er, b);
        end
    endtask

    task automatic send_frame(input bq_t pay, input bit mii, input int period, input int pre_len,
                              input logic [7:0] sfd, input int er_idx, input bit extra);
        for (int i = 0; i < pre_len; i++) put_byte(mii, period, 1'b0, 8'h55);
        put_byte(mii, period, 1'b0, sfd);
        for (int i = 0; i < pay.size(); i++) begin
            put_byte(mii, period, (i == er_idx), pay[i]);
            if (i == 0) t_first = cyc;
        end
        if (extra) put(mii, period, 1'b1, 1'b0, 8'($urandom));
        put(mii, period, 1'b0, 1'b0, 8'h00);
        t_dvlow = cyc;
        for (int i = 0; i < 11; i++) put(mii, period, 1'b0, 1'b0, 8'($urandom));
    endtask

    // Frame-level reference: beats are the payload truncated to MAXL; tuser collects all error causes.
    task automatic check_frame(input string tag, input bq_t pay, input bit sfd_ok, input bit er,
                               input bit odd, input bit fcs_bad, input int b0, input int p0, input int f0);
        int  n, ne, beats;
        bit  over, user, ok, lok;
        n     = sfd_ok ? pay.size() : 0;
        over  = (n > MAXL);
        ne    = over ? MAXL : n;
        user  = over | er | odd;
`ifdef GMII_RX_FCS_CHECK_EN
        user  = user | (fcs_bad & !over);
        chk({tag, ".fcs_pulse"}, n_fcs - f0, (ne > 0 && fcs_bad && !over) ? 1 : 0);
`endif
        beats = act_d.size() - b0;
        chk({tag, ".beats"}, beats, ne);
        chk({tag, ".pulses"}, n_pulse - p0, (ne > 0 && user) ? 1 : 0);
        if (ne > 0 && beats >= ne) begin
            ok  = 1'b1;
            lok = 1'b1;
            for (int i = 0; i < ne; i++) begin
                if (act_d[b0 + i] !== pay[i]) ok = 1'b0;
                if (act_l[b0 + i] !== (i == ne - 1)) lok = 1'b0;
            end
            chk({tag, ".data"}, ok, 1);
            chk({tag, ".tlast"}, lok, 1);
            chk({tag, ".tuser"}, act_u[b0 + ne - 1], user);
            last_len = ne;
        end
        chk({tag, ".frame_len"}, frame_len, last_len);
    endtask

    task automatic run(input string tag, input bq_t pay, input bit mii, input int period, input int pre_len,
                       input logic [7:0] sfd, input int er_idx, input bit extra, input bit fcs_bad);
        int b0, p0, f0;
        b0 = act_d.size();
        p0 = n_pulse;
        f0 = n_fcs;
        send_frame(pay, mii, period, pre_len, sfd, er_idx, extra);
        repeat (4) @(posedge clk);
        #2;
        check_frame(tag, pay, (sfd == 8'hD5), (er_idx >= 0 && er_idx < pay.size()), extra & mii, fcs_bad, b0, p0, f0);
    endtask

    initial begin
        bq_t f64, fb, fo;
        int  b0, p0;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        chk("rst.tvalid", m_axis_tvalid, 0);
        chk("rst.tlast", m_axis_tlast, 0);
        chk("rst.tuser", m_axis_tuser, 0);
        chk("rst.tdata", m_axis_tdata, 0);
        chk("rst.bad_frame", error_bad_frame, 0);
        chk("rst.frame_len", frame_len, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) put(1'b0, 1, 1'b0, 1'b0, 8'h00);

        // GMII clean 64-byte frame, with latency checks.
        f64 = make_frame(60);
        b0 = act_d.size();
        run("gmii_clean", f64, 1'b0, 1, 7, 8'hD5, -1, 1'b0, 1'b0);
        if (act_c.size() >= b0 + 64) begin
            chk("gmii.lat_first", act_c[b0] - t_first, 3);
            chk("gmii.lat_last", act_c[b0 + 63] - t_dvlow, 2);
        end else begin
            chk("gmii.lat_beats", act_c.size() - b0, 64);
        end

        run("gmii_er10", f64, 1'b0, 1, 7, 8'hD5, 10, 1'b0, 1'b0);
        run("mii_clean", f64, 1'b1, 5, 7, 8'hD5, -1, 1'b0, 1'b0);
        run("mii_oddnib", f64, 1'b1, 5, 7, 8'hD5, -1, 1'b1, 1'b0);
        run("gmii_badsfd", f64, 1'b0, 1, 7, 8'h57, -1, 1'b0, 1'b0);
        run("gmii_after_bad", f64, 1'b0, 1, 7, 8'hD5, -1, 1'b0, 1'b0);
        run("gmii_pre1", make_frame(20), 1'b0, 1, 1, 8'hD5, -1, 1'b0, 1'b0);
        run("mii_pre1", make_frame(20), 1'b1, 2, 1, 8'hD5, -1, 1'b0, 1'b0);
        fb.delete();
        run("empty_frame", fb, 1'b0, 1, 7, 8'hD5, -1, 1'b0, 1'b0);

        // clk_enable held low: a full frame on the pins must produce nothing.
        b0 = act_d.size();
        p0 = n_pulse;
        for (int i = 0; i < 100; i++) drv(1'b0, 1'b1, 1'b0, (i < 7) ? 8'h55 : ((i == 7) ? 8'hD5 : 8'($urandom)), 1'b0);
        for (int i = 0; i < 10; i++) drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("noen.beats", act_d.size() - b0, 0);
        chk("noen.pulses", n_pulse - p0, 0);
        chk("noen.frame_len", frame_len, last_len);

        // Length boundaries.
        run("len_max", make_frame(MAXL - 4), 1'b0, 1, 7, 8'hD5, -1, 1'b0, 1'b0);
        run("len_max1", make_frame(MAXL - 3), 1'b0, 1, 7, 8'hD5, -1, 1'b0, 1'b0);
        run("oversize", make_frame(1596), 1'b0, 1, 7, 8'hD5, -1, 1'b0, 1'b0);
        run("after_over", f64, 1'b0, 1, 7, 8'hD5, -1, 1'b0, 1'b0);

        // Reset during byte 20 with dv held high.
        for (int i = 0; i < 7; i++) put_byte(1'b0, 1, 1'b0, 8'h55);
        put_byte(1'b0, 1, 1'b0, 8'hD5);
        for (int i = 0; i <= 20; i++) put_byte(1'b0, 1, 1'b0, f64[i]);
        rst = 1'b1;
        put_byte(1'b0, 1, 1'b0, f64[21]);
        rst = 1'b0;
        chk("midrst.tvalid", m_axis_tvalid, 0);
        chk("midrst.tlast", m_axis_tlast, 0);
        b0 = act_d.size();
        p0 = n_pulse;
        for (int i = 22; i < 64; i++) put_byte(1'b0, 1, 1'b0, f64[i]);
        for (int i = 0; i < 12; i++) put(1'b0, 1, 1'b0, 1'b0, 8'h00);
        chk("midrst.beats", act_d.size() - b0, 0);
        chk("midrst.pulses", n_pulse - p0, 0);
        last_len = 0;
        chk("midrst.frame_len", frame_len, 0);
        run("after_rst", f64, 1'b0, 1, 7, 8'hD5, -1, 1'b0, 1'b0);

`ifdef GMII_RX_FCS_CHECK_EN
        fo = f64;
        fo[30] = fo[30] ^ 8'h01;
        run("fcs_flip", fo, 1'b0, 1, 7, 8'hD5, -1, 1'b0, 1'b1);
`endif

        // Random frames in both modes.
        for (int r = 0; r < 8; r++) begin
            bit m;
            int nd, er_idx;
            m      = 1'($urandom);
            nd     = int'($urandom_range(1, 80));
            fo     = make_frame(nd);
            er_idx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nd + 3)) : -1;
            run($sformatf("rand%0d", r), fo, m, m ? int'($urandom_range(1, 5)) : int'($urandom_range(1, 2)),
                int'($urandom_range(1, 7)), 8'hD5, er_idx, m & 1'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
